// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory controller.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int WAIT_CNT_W = 4;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane steering: write mask, merged store word, load extraction
// and misalignment detection for one 32-bit memory word.
module dmem_lane_unit
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] stored,
   output logic [3:0]  be,
   output logic [31:0] merged,
   output logic [31:0] rdata,
   output logic        misalign
);

   logic [31:0] wpos;

   // Narrow stores are replicated across the word so the mask alone picks the lanes.
   always_comb begin
      be       = 4'b1111;
      wpos     = wdata;
      rdata    = stored;
      misalign = 1'b0;
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << lane;
            wpos  = {4{wdata[7:0]}};
            rdata = {24'b0, stored[{lane, 3'b000} +: 8]};
         end
         SZ_HALF: begin
            be       = lane[1] ? 4'b1100 : 4'b0011;
            wpos     = {2{wdata[15:0]}};
            rdata    = {16'b0, (lane[1] ? stored[31:16] : stored[15:0])};
            misalign = lane[0];
         end
         default: begin
            misalign = |lane;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_merge
         assign merged[8*gi +: 8] = be[gi] ? wpos[8*gi +: 8] : stored[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/dmem_ctrl.sv
// Wait-stated data memory for the MEM stage with ready handshake and range error.
// Define DMEM_ALIGN_CHECK_EN to also flag misaligned half/word accesses as errors.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int          DEPTH       = 64,
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err
);

   localparam int                    IDX_W     = $clog2(DEPTH);
   localparam logic [31:0]           SPAN      = 32'(DEPTH * 4);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);

   state_t                 state_reg;
   logic [WAIT_CNT_W-1:0]  count_reg;
   logic [31:0]            offset_reg;
   logic [31:0]            wdata_reg;
   logic [1:0]             size_reg;
   logic                   write_reg;
   logic [31:0]            rdata_reg;
   logic [31:0]            rd_word_reg;

   logic [31:0]            mem [DEPTH];

   logic                   req;
   logic [31:0]            offset_in;
   logic [IDX_W-1:0]       rd_idx;
   logic [IDX_W-1:0]       acc_idx;
   logic                   done;
   logic                   bad;
   logic [3:0]             be;
   logic [31:0]            merged;
   logic [31:0]            lane_rdata;
   logic                   misalign;

   assign req       = mem_r_en | mem_w_en;
   assign offset_in = addr - BASE_ADDR;
   assign acc_idx   = offset_reg[IDX_W+1:2];
   // In IDLE the read port looks at the incoming address so data is ready one cycle later.
   assign rd_idx    = (state_reg == IDLE) ? offset_in[IDX_W+1:2] : acc_idx;
   assign done      = (state_reg == BUSY) && (count_reg == WAIT_LAST);

`ifdef DMEM_ALIGN_CHECK_EN
   assign bad = (offset_reg >= SPAN) | misalign;
`else
   assign bad = (offset_reg >= SPAN);
`endif

   dmem_lane_unit u_lane (
      .size     (size_reg),
      .lane     (offset_reg[1:0]),
      .wdata    (wdata_reg),
      .stored   (rd_word_reg),
      .be       (be),
      .merged   (merged),
      .rdata    (lane_rdata),
      .misalign (misalign)
   );

   assign ready = rst | ((state_reg == IDLE) & ~req) | done;
   assign err   = ~rst & done & bad;
   assign rdata = (~rst & done & ~write_reg) ? (bad ? 32'd0 : lane_rdata) : rdata_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         offset_reg <= '0;
         wdata_reg  <= '0;
         size_reg   <= SZ_BYTE;
         write_reg  <= 1'b0;
         rdata_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req) begin
                  offset_reg <= offset_in;
                  wdata_reg  <= wdata;
                  size_reg   <= size;
                  write_reg  <= mem_w_en;
                  count_reg  <= WAIT_CNT_W'(1);
                  state_reg  <= BUSY;
               end
            end
            BUSY: begin
               if (done) begin
                  if (!write_reg)
                     rdata_reg <= bad ? 32'd0 : lane_rdata;
                  count_reg <= '0;
                  state_reg <= IDLE;
               end else begin
                  count_reg <= count_reg + WAIT_CNT_W'(1);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         rd_word_reg <= '0;
      else
         rd_word_reg <= mem[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (done && write_reg && !bad) begin
         for (int b = 0; b < 4; b++)
            if (be[b])
               mem[acc_idx][8*b +: 8] <= merged[8*b +: 8];
      end
   end

endmodule
